// File: rtl/sprite_pkg.sv
// Shared sprite constants and the tag-pipeline stage type for the sprite ROM arbiter.
package sprite_pkg;

  localparam int unsigned SPRITE_ID_W = 6;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned ADDR_W      = SPRITE_ID_W + PIX_W;
  localparam int unsigned TAG_W       = 3;

  localparam logic [SPRITE_ID_W-1:0] NULL_ID     = 6'd63;
  localparam logic [11:0]            TRANSPARENT = 12'h000;

  // Coin animation frames occupy a contiguous id range
  localparam logic [SPRITE_ID_W-1:0] COIN_ID_FIRST = 6'd4;
  localparam logic [SPRITE_ID_W-1:0] COIN_ID_LAST  = 6'd7;

  typedef struct packed {
    logic             valid;
    logic             is_null;
    logic [TAG_W-1:0] tag;
  } tag_stage_t;

  function automatic logic is_coin_id(input logic [SPRITE_ID_W-1:0] id);
    return (id >= COIN_ID_FIRST) && (id <= COIN_ID_LAST);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot picker: first set req bit after ptr, with wrap.
module rr_pick
  import sprite_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (int'(ptr) + k) % int'(N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite-pixel ROM port; tagged responses after 1+ROM_LAT cycles.
// Define ARB_FIXED_PRIO0_EN to give requester 0 absolute priority over the others.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned COLOR_W = 12,
  parameter logic [5:0]  NULL_ID = sprite_pkg::NULL_ID,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(sprite_pkg::TRANSPARENT)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N-1:0]             req,
  input  logic [SPRITE_ID_W*N-1:0] req_id,
  input  logic [PIX_W*N-1:0]       req_pix,
  output logic [N-1:0]             gnt,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [COLOR_W-1:0]       rom_data,
  output logic                     rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [COLOR_W-1:0]       rsp_data
);

  logic [TAG_W-1:0]       ptr;
  logic [N-1:0]           req_m;
  logic [N-1:0]           gnt_rr;
  logic [N-1:0]           gnt_sel;
  logic                   accept;
  logic [TAG_W-1:0]       gnt_idx;
  logic [SPRITE_ID_W-1:0] id_sel;
  logic [PIX_W-1:0]       pix_sel;
  logic                   sel_null;
  tag_stage_t             pipe [ROM_LAT+1];

`ifdef ARB_FIXED_PRIO0_EN
  // Requester 0 is masked out of the rotation and wins outright when requesting
  assign req_m   = req & ~N'(1);
  assign gnt_sel = req[0] ? N'(1) : gnt_rr;
`else
  assign req_m   = req;
  assign gnt_sel = gnt_rr;
`endif

  rr_pick #(.N(N)) u_rr_pick (
    .req (req_m),
    .ptr (ptr),
    .gnt (gnt_rr)
  );

  assign gnt    = rstn ? gnt_sel : '0;
  assign accept = |gnt;

  // Decode the one-hot grant into an index and mux the winner's id/pixel
  always_comb begin
    gnt_idx = '0;
    id_sel  = '0;
    pix_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) begin
        gnt_idx = TAG_W'(i);
        id_sel  = req_id[i*SPRITE_ID_W +: SPRITE_ID_W];
        pix_sel = req_pix[i*PIX_W +: PIX_W];
      end
    end
  end

  assign sel_null = (id_sel == NULL_ID);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr       <= TAG_W'(N - 1);
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
      for (int s = 0; s <= int'(ROM_LAT); s++) begin
        pipe[s] <= '0;
      end
    end else begin
      rom_en <= accept && !sel_null;
      if (accept && !sel_null) begin
        rom_addr <= {id_sel, pix_sel};
      end

`ifdef ARB_FIXED_PRIO0_EN
      if (accept && (gnt_idx != '0)) begin
        ptr <= gnt_idx;
      end
`else
      if (accept) begin
        ptr <= gnt_idx;
      end
`endif

      pipe[0].valid   <= accept;
      pipe[0].is_null <= accept && sel_null;
      pipe[0].tag     <= gnt_idx;
      for (int s = 1; s <= int'(ROM_LAT); s++) begin
        pipe[s] <= pipe[s-1];
      end

      // Last stage lines up with rom_data for its own read
      rsp_valid <= pipe[ROM_LAT].valid;
      if (pipe[ROM_LAT].valid) begin
        rsp_tag  <= pipe[ROM_LAT].tag;
        rsp_data <= pipe[ROM_LAT].is_null ? TRANSPARENT : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter (N=4, ROM_LAT=1) with a one-cycle ROM model.
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [23:0] req_id;
  logic [31:0] req_pix;
  logic [3:0]  gnt;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic        rsp_valid;
  logic [2:0]  rsp_tag;
  logic [11:0] rsp_data;

  int checks;
  int errors;

  sprite_rom_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_id    (req_id),
    .req_pix   (req_pix),
    .gnt       (gnt),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] romf(input logic [13:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  // Synchronous ROM, one cycle read latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= romf(rom_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = '0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic set_src(input int i, input logic [5:0] id, input logic [7:0] pix);
    req_id[i*6 +: 6]  = id;
    req_pix[i*8 +: 8] = pix;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 4'b1111;
    tick();
    tick();
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
    checks++; if (rom_addr !== 14'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_tag !== 3'd0) begin errors++; $display("FAIL reset_rsp_tag: got %0d want 0", rsp_tag); end
    checks++; if (rsp_data !== 12'h000) begin errors++; $display("FAIL reset_rsp_data: got %h want 000", rsp_data); end
    req  = '0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 6'd5, 8'h3A);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick();
    req = '0;
    checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL single_rom_en: got %b want 1", rom_en); end
    checks++; if (rom_addr !== 14'h053A) begin errors++; $display("FAIL single_rom_addr: got %h want 053a", rom_addr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    tick();
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL single_rom_en_drop: got %b want 0", rom_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_lat1: got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_tag !== 3'd0) begin errors++; $display("FAIL single_rsp_tag: got %0d want 0", rsp_tag); end
    checks++; if (rsp_data !== 12'hF60) begin errors++; $display("FAIL single_rsp_data: got %h want f60", rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 12'hF60) begin errors++; $display("FAIL single_idle_hold: got %h want f60", rsp_data); end
  endtask

  task automatic test_all_req();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(8 + i), 8'(17 * i));
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      logic [3:0]  exp_gnt;
      int          k;
      int          idx;
      logic [13:0] a;
      if (c == 8) req = '0;
      #1;
      if (c < 8) begin
`ifdef ARB_FIXED_PRIO0_EN
        exp_gnt = 4'b0001;
`else
        exp_gnt = 4'(1 << (c % 4));
`endif
        checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL all_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      end
      if (c >= 3 && c < 11) begin
        k = c - 3;
`ifdef ARB_FIXED_PRIO0_EN
        idx = 0;
`else
        idx = k % 4;
`endif
        a = {6'(8 + idx), 8'(17 * idx)};
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL all_rsp_valid c=%0d: got %b want 1", c, rsp_valid); end
        checks++; if (rsp_tag !== 3'(idx)) begin errors++; $display("FAIL all_rsp_tag c=%0d: got %0d want %0d", c, rsp_tag, idx); end
        checks++; if (rsp_data !== romf(a)) begin errors++; $display("FAIL all_rsp_data c=%0d: got %h want %h", c, rsp_data, romf(a)); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL all_rsp_idle c=%0d: got %b want 0", c, rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_null();
    do_reset();
    set_src(1, 6'd9, 8'h21);
    set_src(2, 6'd63, 8'h44);
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL null_gnt1: got %b want 0010", gnt); end
    tick();
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL null_gnt2: got %b want 0100", gnt); end
    checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL null_rom_en1: got %b want 1", rom_en); end
    checks++; if (rom_addr !== 14'h0921) begin errors++; $display("FAIL null_rom_addr1: got %h want 0921", rom_addr); end
    tick();
    req = '0;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL null_rom_en: got %b want 0", rom_en); end
    checks++; if (rom_addr !== 14'h0921) begin errors++; $display("FAIL null_addr_hold: got %h want 0921", rom_addr); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 3'd1 || rsp_data !== 12'h37B) begin
      errors++; $display("FAIL null_prev_rsp: got v=%b t=%0d d=%h want v=1 t=1 d=37b", rsp_valid, rsp_tag, rsp_data);
    end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL null_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_tag !== 3'd2) begin errors++; $display("FAIL null_rsp_tag: got %0d want 2", rsp_tag); end
    checks++; if (rsp_data !== 12'h000) begin errors++; $display("FAIL null_rsp_data: got %h want 000", rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL null_idle: got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(20 + i), 8'h10);
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt_setup: got %b want 0010", gnt); end
    tick();
    req = 4'b1001;
    #1;
`ifdef ARB_FIXED_PRIO0_EN
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt_first: got %b want 0001", gnt); end
`else
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt_first: got %b want 1000", gnt); end
`endif
    tick();
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt_second: got %b want 0001", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(30 + i), 8'h55);
    req = 4'b1111;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_in_reset: got %b want 0000", gnt); end
    tick();
    rstn = 1'b1;
    req  = '0;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL mid_rom_en: got %b want 0", rom_en); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rsp c=%0d: got %b want 0", c, rsp_valid); end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(40 + i), 8'h07);
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      logic [3:0] exp_gnt;
      #1;
`ifdef ARB_FIXED_PRIO0_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'(1 << c);
`endif
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL prio_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      tick();
    end
    req = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      logic [3:0] exp_gnt;
      #1;
      exp_gnt = 4'(1 << (c + 1));
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL prio_rr_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      tick();
    end
    req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    req      = '0;
    req_id   = '0;
    req_pix  = '0;
    rom_data = '0;
    test_reset();
    test_single();
    test_all_req();
    test_null();
    test_wrap();
    test_reset_mid();
    test_fixed_prio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite-pixel ROM port among N requesters (coin, Mario, enemy and block renderers).
- Each requester presents a 6-bit sprite id and an 8-bit in-tile pixel index (16x16 tile).
- The arbiter grants one requester per cycle in round-robin order and drives the ROM address.
- It returns colour data tagged with the requester index after a fixed latency; the null sprite id bypasses the ROM.

Parameters:
- N, 4, number of requesters (2..8)
- ROM_LAT, 1, ROM read latency in cycles from rom_en to valid rom_data (1..3)
- COLOR_W, 12, pixel colour width
- NULL_ID, 63, sprite id meaning "no sprite"
- TRANSPARENT, 12'h000, colour returned for NULL_ID

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- req  in  N  per-requester request, level
- req_id  in  6*N  sprite id, requester i at [6i+5:6i]
- req_pix  in  8*N  pixel index {y[3:0],x[3:0]}, requester i at [8i+7:8i]
- gnt  out  N  one-hot grant, combinational, same cycle as accept
- rom_en  out  1  registered ROM read enable
- rom_addr  out  14  registered {id, pix}
- rom_data  in  COLOR_W  ROM read data
- rsp_valid  out  1  response valid, one cycle
- rsp_tag  out  3  requester index of the response
- rsp_data  out  COLOR_W  pixel colour

Behaviour:
- Reset (rstn=0 at posedge): rom_en=0, rom_addr=0, rsp_valid=0, rsp_tag=0, rsp_data=0, rr pointer=N-1, tag pipeline cleared. gnt=0 while rstn=0.
- Arbitration: combinational. Search req starting at (ptr+1) mod N with wrap; first hit gets gnt. At most one gnt bit is set. gnt=0 when req=0.
- Acceptance:
  - Request i is accepted on the posedge where gnt[i]=1.
  - At that edge, ptr<=i.
  - If req_id_i != NULL_ID: rom_en<=1 and rom_addr<={req_id_i,req_pix_i}.
  - Otherwise rom_en<=0 and rom_addr holds its value.
- Requesters drop or change req/id/pix on the cycle after their grant. Holding req high means a new request, re-arbitrated fairly.
- Tag pipeline: depth 1+ROM_LAT. Each stage holds {valid, null, tag}. Stage 0 is loaded at accept; it shifts every cycle with no stalls.
- Response: rsp_valid=1 exactly 1+ROM_LAT cycles after the accept edge (default 2). rsp_data = rom_data, or TRANSPARENT if null. All three response outputs are registered.
- Throughput: one accept per cycle; back-to-back accepts produce back-to-back responses in grant order.
- Idle cycles leave rsp_data unchanged and set rsp_valid=0.
- Reset mid-operation: in-flight responses are discarded; no rsp_valid after reset deasserts until a new accept.
- Fairness: with all N requesting continuously, each requester is granted exactly once every N cycles.

Optional Feature:
- Macro ARB_FIXED_PRIO0_EN.
  - Defined: requester 0 (Mario) wins whenever req[0]=1. The others round-robin among themselves, and ptr updates only on grants to requesters 1..N-1.
  - Undefined: pure round-robin over all N as above.

Decomposition:
- Shared package sprite_pkg: NULL_ID, TRANSPARENT, the coin frame ids 4..7, SPRITE_ID_W=6, PIX_W=8, and a tag-stage struct {valid, null, tag}.
- One natural sub-module, rr_pick: combinational N-bit round-robin one-hot picker taking req and ptr. Reused by the fixed-priority variant with the bit-0 mask.

Test Plan:
1. Reset then req=4'b0001, id0=5, pix0=8'h3A. Expect:
   - gnt=0001 in the request cycle.
   - Next cycle rom_en=1, rom_addr={6'd5,8'h3A}.
   - 2 cycles after accept, rsp_valid=1, rsp_tag=0, rsp_data=rom_data.
2. All four req held high for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and responses in the same order, back-to-back, each 2 cycles after its grant.
3. req=0100 with id2=63. Expect:
   - rom_en stays 0.
   - 2 cycles later rsp_valid=1, rsp_tag=2, rsp_data=TRANSPARENT.
4. ptr=1 with req=1001. Expect gnt=1000, then gnt=0001 on the following cycle (wrap-around).
5. Issue 3 accepts, then assert rstn=0 for 1 cycle. Expect rsp_valid=0 through and after reset, with no stale responses.
6. With ARB_FIXED_PRIO0_EN defined, req0 held high and req=1111 for 4 cycles. Expect gnt=0001 every cycle. After dropping req0, gnt=0010, 0100, 1000.
